rbs_pipelined_sub: RTL and testbench
====================================

Name: rbs_pipelined_sub

Overview:
- Pipelined ripple-borrow subtractor; the inverse of the team's pipelined ripple-carry adder.
- Computes diff = a - b - bin with a borrow out, split into STAGES register ranks.
- A valid bit travels with each operand set, so a full-rate stream can be checked against adder outputs.
- Used in the datapath wherever adder results must be undone or compared.

Parameters:
- WIDTH, 8, operand and result width in bits.
- STAGES, 4, number of pipeline ranks. WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH; elaboration fails otherwise.
- SLICE, WIDTH/STAGES (derived, not overridable), bits resolved per stage.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register in the block.
- in_valid  in  1  marks a, b and bin as a valid operand set this cycle.
- a  in  WIDTH  minuend, unsigned or two's complement.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  diff, bout and ovf are valid.
- diff  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  out  1  borrow out; 1 iff unsigned a < b + bin.
- ovf  out  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset: rst_n low clears every pipeline register, including the valid chain, immediately and independent of clk. While rst_n is low: out_valid=0, diff=0, bout=0, ovf=0.
- Stage k (0..STAGES-1) resolves bits [k*SLICE +: SLICE] using the borrow registered by stage k-1. Stage 0 uses bin.
- Skew registers carry the unresolved upper bits of a and b forward. Deskew registers delay the already-resolved lower diff slices so that all slices align at the output.
- Latency: operands presented in cycle t with ce=1 on every intervening edge appear on the outputs in cycle t+STAGES. Throughput is one operand set per cycle.
- Valid chain: in_valid shifts alongside the data, and out_valid equals in_valid delayed by STAGES enabled edges.
- Data registers load every enabled edge regardless of in_valid, so data is don't-care when out_valid=0. The bench must ignore outputs while out_valid=0.
- Arithmetic is unsigned modulo 2^WIDTH:
  - bout is the final stage borrow.
  - ovf is computed in the last stage from the registered MSBs of a and b and the final diff MSB.
- ce=0:
  - All ranks hold and outputs stay constant.
  - in_valid and operands are ignored that cycle, with no loss of in-flight data.
  - Latency counts only enabled edges.
- Reset mid-stream: all in-flight results are discarded. The first out_valid after reset release comes from operands presented after release.
- Boundaries:
  - a=b, bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all-ones, bout=1.
  - a=all-ones, b=0, bin=0 gives no borrow.
  - STAGES=1 is a single registered subtractor with latency 1.
  - STAGES=WIDTH means one bit per stage.
- There are no combinational paths from inputs to outputs.

Test Plan (WIDTH=8, STAGES=4):
- Hold rst_n=0, then release; present a=1, b=1, bin=0 with in_valid=1 in cycle t. Required: exactly cycle t+4 shows out_valid=1, diff=0x00, bout=0, ovf=0; outputs were 0 during reset.
- Back-to-back stream, one set per cycle with in_valid=1:
  - (3,7,1) gives diff=0xFB, bout=1.
  - (0x80,0x01,0) gives diff=0x7F, bout=0, ovf=1.
  - (0,0,1) gives diff=0xFF, bout=1.
  - (0xFF,0x00,0) gives diff=0xFF, bout=0.
  - Required: results on four consecutive cycles starting t+4, in order.
- Stall: issue (13,1,1), then hold ce=0 for 3 cycles after 2 enabled edges. Required: outputs frozen during the stall; diff=0x0B, bout=0 appears 4 enabled edges after issue.
- Gaps: alternate in_valid 1/0 with (6,0,1). Required: out_valid pattern 1,0,1,0 delayed 4 cycles; every valid result is diff=0x05.
- Reset mid-stream: pulse rst_n low for a partial cycle while 3 results are in flight. Required: out_valid drops at once and no stale result emerges after release.
- Round trip with the pipelined adder: feed sum=0x96 and cout=0 (from 0x5A+0x3C, carry in 0) as a and b=0x3C, bin=0. Required: diff=0x5A, bout=0. Then randomly sweep 1000 vectors against the reference model a-b-bin.

Source files
------------

// File: rtl/rbs_if.sv
// Operand/result bundle for the pipelined ripple-borrow subtractor.
// The master drives operands; the slave (the subtractor) returns results.
interface rbs_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output in_valid, a, b, bin, input  out_valid, diff, bout, ovf);
  modport slave  (input  in_valid, a, b, bin, output out_valid, diff, bout, ovf);
endinterface

// File: rtl/rbs_pipelined_sub.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin over STAGES ranks.
// Each rank resolves one SLICE and forwards the borrow, the operands and the partial diff.
module rbs_pipelined_sub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ce,
  rbs_if.slave  bus
);
  localparam int SLICE = WIDTH / STAGES;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("rbs_pipelined_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  // q arrays hold the output of rank k; stage k reads rank k-1 (or the ports for k=0)
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [STAGES-1:0] br_q;
  logic [STAGES-1:0] vld_pipe;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  d_n [STAGES];
  logic [STAGES-1:0] br_n;
  logic              ovf_n;

  always_comb begin
    logic [WIDTH-1:0] ai, bi, di;
    logic             bri;
    logic [SLICE:0]   r;
    int               j;
    ai    = '0;
    bi    = '0;
    di    = '0;
    bri   = 1'b0;
    r     = '0;
    br_n  = '0;
    ovf_n = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      j   = (k > 0) ? k - 1 : 0;
      ai  = (k == 0) ? bus.a   : a_q[j];
      bi  = (k == 0) ? bus.b   : b_q[j];
      di  = (k == 0) ? '0      : d_q[j];
      bri = (k == 0) ? bus.bin : br_q[j];
      // extra top bit of the slice difference goes to 1 exactly when it borrows
      r = {1'b0, ai[k*SLICE +: SLICE]} - {1'b0, bi[k*SLICE +: SLICE]} - {{SLICE{1'b0}}, bri};
      a_n[k] = ai;
      b_n[k] = bi;
      d_n[k] = di;
      d_n[k][k*SLICE +: SLICE] = r[SLICE-1:0];
      br_n[k] = r[SLICE];
    end
    // ai/bi now hold the last stage's inputs, i.e. the registered operand MSBs
    ovf_n = (ai[WIDTH-1] ^ bi[WIDTH-1]) & (d_n[STAGES-1][WIDTH-1] ^ ai[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
      br_q     <= '0;
      vld_pipe <= '0;
      ovf_q    <= 1'b0;
    end else if (ce) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        d_q[k] <= d_n[k];
      end
      br_q     <= br_n;
      vld_pipe <= (vld_pipe << 1) | STAGES'(bus.in_valid);
      ovf_q    <= ovf_n;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.diff      = d_q[STAGES-1];
  assign bus.bout      = br_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rbs_pipelined_sub.sv
// Self-checking bench for rbs_pipelined_sub (WIDTH=8, STAGES=4): directed latency/stall/reset
// scenarios plus a scoreboard fed at issue time and drained by a negedge monitor.
module tb_rbs_pipelined_sub;
  localparam int WIDTH  = 8;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  logic clk, rst_n, ce;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic edge_en = 1'b0;

  rbs_if #(.WIDTH(WIDTH)) bus ();
  rbs_pipelined_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    logic [WIDTH:0] f;
    exp_t e;
    f    = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    e.d  = f[WIDTH-1:0];
    e.bo = f[WIDTH];
    e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // One clock: drive operands, record the expectation if the edge captures them.
  task automatic step(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    bus.bin      = c;
    @(posedge clk);
    if (v && ce && rst_n) sb.push_back(model(x, y, c));
    #1;
  endtask

  always @(posedge clk) edge_en = ce && rst_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && edge_en && bus.out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: out_valid=1 diff=%h with no result pending", bus.diff);
      end else begin
        e = sb.pop_front();
        if ({bus.diff, bus.bout, bus.ovf} !== e) begin
          failures++;
          $display("FAIL sb_result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                   bus.diff, bus.bout, bus.ovf, e.d, e.bo, e.ov);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ce    = 1'b1;
    bus.in_valid = 1'b1; bus.a = 8'h55; bus.b = 8'h23; bus.bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%b diff=%h bout=%b ovf=%b want all 0",
               bus.out_valid, bus.diff, bus.bout, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'd1, 8'd1, 1'b0);
    for (int i = 1; i <= STAGES; i++) begin
      checks++;
      if (bus.out_valid !== (i == STAGES)) begin
        failures++;
        $display("FAIL first_latency: edge %0d out_valid=%b want %b", i, bus.out_valid, (i == STAGES));
      end
      if (i == STAGES) begin
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== 10'd0) begin
          failures++;
          $display("FAIL first_result: got diff=%h bout=%b ovf=%b want 00/0/0", bus.diff, bus.bout, bus.ovf);
        end
      end else step(1'b0, 8'd0, 8'd0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4] = '{8'd3,  8'h80, 8'd0,  8'hFF};
    logic [7:0] vb [4] = '{8'd7,  8'h01, 8'd0,  8'h00};
    logic       vc [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] ed [4] = '{8'hFB, 8'h7F, 8'hFF, 8'hFF};
    logic       eb [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
    logic       eo [4] = '{1'b0,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 4; i++) step(1'b1, va[i], vb[i], vc[i]);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== {1'b1, ed[j], eb[j], eo[j]}) begin
        failures++;
        $display("FAIL b2b_%0d: got vld=%b diff=%h bout=%b ovf=%b want 1 %h %b %b",
                 j, bus.out_valid, bus.diff, bus.bout, bus.ovf, ed[j], eb[j], eo[j]);
      end
      step(1'b0, 8'd0, 8'd0, 1'b0);
    end
  endtask

  task automatic test_stall();
    logic [10:0] snap;
    repeat (STAGES) step(1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b1, 8'd13, 8'd1, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    snap = {bus.out_valid, bus.diff, bus.bout, bus.ovf};
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      checks++;
      if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== snap) begin
        failures++;
        $display("FAIL stall_frozen: cycle %0d got %h want %h", i,
                 {bus.out_valid, bus.diff, bus.bout, bus.ovf}, snap);
      end
    end
    ce = 1'b1;
    step(1'b0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_early: out_valid=%b after 3 enabled edges want 0", bus.out_valid);
    end
    step(1'b0, 8'd0, 8'd0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.diff, bus.bout} !== {1'b1, 8'h0B, 1'b0}) begin
      failures++;
      $display("FAIL stall_result: got vld=%b diff=%h bout=%b want 1 0b 0", bus.out_valid, bus.diff, bus.bout);
    end
  endtask

  task automatic test_gaps();
    logic ev;
    repeat (STAGES) step(1'b0, 8'd0, 8'd0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      step((n <= 4) ? logic'(n % 2) : 1'b0, 8'd6, 8'd0, 1'b1);
      if (n >= STAGES && n <= STAGES + 3) begin
        ev = ((n - STAGES) % 2 == 0);
        checks++;
        if (bus.out_valid !== ev || (ev && bus.diff !== 8'h05)) begin
          failures++;
          $display("FAIL gaps_edge%0d: got vld=%b diff=%h want vld=%b diff=05", n, bus.out_valid, bus.diff, ev);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i * 17 + 9), 8'(i), 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: out_valid=%b want 1", bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== 11'd0) begin
      failures++;
      $display("FAIL mid_async: got vld=%b diff=%h want 0 00", bus.out_valid, bus.diff);
    end
    sb.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale: edge %0d out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_round_trip();
    step(1'b1, 8'h96, 8'h3C, 1'b0);
    repeat (STAGES - 1) step(1'b0, 8'd0, 8'd0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.diff, bus.bout} !== {1'b1, 8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL round_trip: got vld=%b diff=%h bout=%b want 1 5a 0", bus.out_valid, bus.diff, bus.bout);
    end
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 1000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    ce = 1'b1;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      step(1'b0, 8'd0, 8'd0, 1'b0);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL random_drain: %0d results never emerged", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_reset_midstream();
    test_round_trip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
